// File: rtl/driver_display.sv
// -----------------------------------------------------------------------------
// driver_display
//
// Three-digit time-multiplexed seven-segment display driver. Digits arriving
// from the binary-to-BCD stage are captured on a load strobe into pending
// registers and copied to the display registers only at frame boundaries, so
// a frame never shows a mix of old and new digits. One digit is lit per slot,
// with a short anode-off window at the start of every slot to suppress
// ghosting. Leading zeros can optionally be blanked.
//
// Parameters:
//   REFRESH_DIV  cycles per digit slot (>= 2)
//   BLANK_CYC    anode-off cycles at the start of each slot (< REFRESH_DIV)
//   ACTIVE_LOW   1 = invert segmentos/anodos at the pins (common-anode board)
//
// Ports:
//   clock         in   single clock, rising edge
//   reset         in   synchronous, active-high
//   carregar      in   load strobe for the three digit inputs
//   centena       in   hundreds BCD digit
//   dezena        in   tens BCD digit
//   unidade       in   units BCD digit
//   apagar_zeros  in   leading-zero blanking enable (level)
//   segmentos     out  {g,f,e,d,c,b,a}, registered
//   anodos        out  [0]=unidade, [1]=dezena, [2]=centena, registered
//   quadro        out  one-cycle end-of-frame pulse, registered
// -----------------------------------------------------------------------------
module driver_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carregar,
    input  logic [3:0] centena,
    input  logic [3:0] dezena,
    input  logic [3:0] unidade,
    input  logic       apagar_zeros,
    output logic [6:0] segmentos,
    output logic [2:0] anodos,
    output logic       quadro
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    // Slot index doubles as the digit selector.
    typedef enum logic [1:0] {
        SLOT_UNI = 2'd0,
        SLOT_DEZ = 2'd1,
        SLOT_CEN = 2'd2
    } slot_t;

    logic [CW-1:0] r_cnt;
    slot_t         r_slot;

    logic          r_pend;
    logic [3:0]    r_pend_cen;
    logic [3:0]    r_pend_dez;
    logic [3:0]    r_pend_uni;

    logic [3:0]    r_disp_cen;
    logic [3:0]    r_disp_dez;
    logic [3:0]    r_disp_uni;

    // Output registers hold the active-high view; inversion happens at the pins.
    logic [6:0]    r_seg;
    logic [2:0]    r_an;
    logic          r_quadro;

    logic          w_slot_end;
    logic          w_boundary;
    logic          w_lit;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [2:0]    w_an_sel;
    logic [6:0]    w_seg_code;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = 7'h40;   // non-BCD input shows a dash
        endcase
        return code;
    endfunction

    assign w_slot_end = (r_cnt == CNT_MAX);
    assign w_boundary = w_slot_end && (r_slot == SLOT_CEN);
    assign w_lit      = (r_cnt >= CNT_BLANK);

    // NOTE: every signal driven in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_digit  = r_disp_uni;
        w_blank  = 1'b0;
        w_an_sel = 3'b000;
        case (r_slot)
            SLOT_UNI: begin
                w_digit  = r_disp_uni;
                w_an_sel = 3'b001;
            end
            SLOT_DEZ: begin
                w_digit  = r_disp_dez;
                // Tens are only a leading zero when the hundreds are too.
                w_blank  = apagar_zeros && (r_disp_cen == 4'd0) && (r_disp_dez == 4'd0);
                w_an_sel = 3'b010;
            end
            SLOT_CEN: begin
                w_digit  = r_disp_cen;
                w_blank  = apagar_zeros && (r_disp_cen == 4'd0);
                w_an_sel = 3'b100;
            end
            default: begin
                w_digit  = r_disp_uni;
                w_an_sel = 3'b000;
            end
        endcase
    end

    assign w_seg_code = w_blank ? 7'h00 : seg_encode(w_digit);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_slot     <= SLOT_UNI;
            r_pend     <= 1'b0;
            r_pend_cen <= 4'd0;
            r_pend_dez <= 4'd0;
            r_pend_uni <= 4'd0;
            r_disp_cen <= 4'd0;
            r_disp_dez <= 4'd0;
            r_disp_uni <= 4'd0;
            r_seg      <= 7'h00;
            r_an       <= 3'b000;
            r_quadro   <= 1'b0;
        end else begin
            // Slot counter and slot index.
            if (w_slot_end) begin
                r_cnt <= '0;
                case (r_slot)
                    SLOT_UNI: r_slot <= SLOT_DEZ;
                    SLOT_DEZ: r_slot <= SLOT_CEN;
                    default:  r_slot <= SLOT_UNI;
                endcase
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Display registers change only at the frame boundary. A strobe in
            // the boundary cycle itself bypasses the pending stage.
            if (w_boundary) begin
                if (carregar) begin
                    r_disp_cen <= centena;
                    r_disp_dez <= dezena;
                    r_disp_uni <= unidade;
                end else if (r_pend) begin
                    r_disp_cen <= r_pend_cen;
                    r_disp_dez <= r_pend_dez;
                    r_disp_uni <= r_pend_uni;
                end
                r_pend <= 1'b0;
            end else if (carregar) begin
                r_pend_cen <= centena;
                r_pend_dez <= dezena;
                r_pend_uni <= unidade;
                r_pend     <= 1'b1;
            end

            // Outputs: one-cycle registered view of the current slot.
            r_seg    <= w_lit ? w_seg_code : 7'h00;
            r_an     <= w_lit ? w_an_sel : 3'b000;
            r_quadro <= w_boundary;
        end
    end

    assign segmentos = ACTIVE_LOW ? ~r_seg : r_seg;
    assign anodos    = ACTIVE_LOW ? ~r_an  : r_an;
    assign quadro    = r_quadro;

endmodule

// File: tb/tb_driver_display.sv
// -----------------------------------------------------------------------------
// tb_driver_display
//
// Directed bench for driver_display with REFRESH_DIV=8, BLANK_CYC=2. Two
// instances share every input: dut_h drives active-high pins, dut_l drives
// active-low pins. A frame is 24 cycles; cyc counts cycles since the last
// reset release, so cyc % 24 is the internal frame phase (slot = phase / 8,
// cnt = phase % 8). Outputs lag the internal state by one cycle, so the value
// sampled at phase p describes phase p-1.
// -----------------------------------------------------------------------------
module tb_driver_display;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       carregar = 1'b0;
    logic [3:0] centena = 4'd0;
    logic [3:0] dezena = 4'd0;
    logic [3:0] unidade = 4'd0;
    logic       apagar_zeros = 1'b0;

    logic [6:0] seg_h, seg_l;
    logic [2:0] an_h, an_l;
    logic       q_h, q_l;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    driver_display #(.REFRESH_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(1'b0)) dut_h (
        .clock        (clock),
        .reset        (reset),
        .carregar     (carregar),
        .centena      (centena),
        .dezena       (dezena),
        .unidade      (unidade),
        .apagar_zeros (apagar_zeros),
        .segmentos    (seg_h),
        .anodos       (an_h),
        .quadro       (q_h)
    );

    driver_display #(.REFRESH_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(1'b1)) dut_l (
        .clock        (clock),
        .reset        (reset),
        .carregar     (carregar),
        .centena      (centena),
        .dezena       (dezena),
        .unidade      (unidade),
        .apagar_zeros (apagar_zeros),
        .segmentos    (seg_l),
        .anodos       (an_l),
        .quadro       (q_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock; inputs and samples both sit 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int phase);
        while ((cyc % 24) != phase) step();
    endtask

    task automatic load_at(input int phase, input logic [3:0] c, input logic [3:0] d,
                           input logic [3:0] u);
        go_to(phase);
        centena  = c;
        dezena   = d;
        unidade  = u;
        carregar = 1'b1;
        step();
        carregar = 1'b0;
    endtask

    // Sample mid-slot (shows internal cnt=4 of slot k).
    task automatic observe_slot(input string tag, input int k, input logic [6:0] exp_seg);
        logic [2:0] exp_an;
        exp_an = 3'b000;
        exp_an[k] = 1'b1;
        go_to(8 * k + 5);
        check($sformatf("%s_an%0d", tag, k), an_h, exp_an);
        check($sformatf("%s_seg%0d", tag, k), seg_h, exp_seg);
    endtask

    initial begin
        // Reset held: both polarities.
        step();
        step();
        check("rst_seg_h", seg_h, 7'h00);
        check("rst_an_h", an_h, 3'b000);
        check("rst_q_h", q_h, 1'b0);
        check("rst_seg_l", seg_l, 7'h7F);
        check("rst_an_l", an_l, 3'b111);

        // Scan timing: reset released, this is cycle 0.
        reset = 1'b0;
        cyc = 0;
        for (int c = 0; c < 27; c++) begin
            logic [2:0] exp_an;
            exp_an = 3'b000;
            if (c >= 3 && c <= 8)        exp_an = 3'b001;
            else if (c >= 11 && c <= 16) exp_an = 3'b010;
            else if (c >= 19 && c <= 24) exp_an = 3'b100;
            check($sformatf("scan_an_c%0d", c), an_h, exp_an);
            // Boundary cycle is 23 (slot 2, cnt 7); the pulse shows in 24.
            check($sformatf("scan_q_c%0d", c), q_h, (c == 24));
            if (exp_an == 3'b000)
                check($sformatf("scan_seg_c%0d", c), seg_h, 7'h00);
            step();
        end

        // Encoding.
        load_at(22, 4'd1, 4'd2, 4'd3);
        observe_slot("enc", 0, 7'h4F);
        observe_slot("enc", 1, 7'h5B);
        observe_slot("enc", 2, 7'h06);
        load_at(22, 4'd1, 4'd2, 4'd12);
        observe_slot("dash", 0, 7'h40);

        // Leading-zero blanking.
        apagar_zeros = 1'b1;
        load_at(22, 4'd0, 4'd0, 4'd7);
        observe_slot("lz007", 0, 7'h07);
        observe_slot("lz007", 1, 7'h00);
        observe_slot("lz007", 2, 7'h00);
        load_at(22, 4'd0, 4'd5, 4'd0);
        observe_slot("lz050", 0, 7'h3F);
        observe_slot("lz050", 1, 7'h6D);
        observe_slot("lz050", 2, 7'h00);
        load_at(22, 4'd0, 4'd0, 4'd7);
        apagar_zeros = 1'b0;
        observe_slot("nolz007", 0, 7'h07);
        observe_slot("nolz007", 1, 7'h3F);
        observe_slot("nolz007", 2, 7'h3F);

        // Tear-free update: 9s loaded while slot 1 is lit.
        load_at(22, 4'd1, 4'd1, 4'd1);
        observe_slot("tear_old", 0, 7'h06);
        load_at(12, 4'd9, 4'd9, 4'd9);
        observe_slot("tear_old", 1, 7'h06);
        observe_slot("tear_old", 2, 7'h06);
        observe_slot("tear_new", 0, 7'h6F);
        observe_slot("tear_new", 1, 7'h6F);
        observe_slot("tear_new", 2, 7'h6F);

        // Pending 2s overridden by a live load in the boundary cycle.
        load_at(22, 4'd2, 4'd2, 4'd2);
        load_at(23, 4'd3, 4'd3, 4'd3);
        observe_slot("bnd", 0, 7'h4F);
        observe_slot("bnd", 1, 7'h4F);
        observe_slot("bnd", 2, 7'h4F);

        // Reset mid-frame, with a pending load that must be discarded.
        load_at(22, 4'd8, 4'd8, 4'd8);
        observe_slot("pre_rst", 0, 7'h7F);
        check("pol_seg_l", seg_l, 7'h00);
        check("pol_an_l", an_l, 3'b110);
        load_at(10, 4'd5, 4'd5, 4'd5);
        go_to(12);
        reset = 1'b1;
        step();
        cyc = 0;
        check("midrst_an", an_h, 3'b000);
        check("midrst_seg", seg_h, 7'h00);
        check("midrst_q", q_h, 1'b0);
        check("midrst_seg_l", seg_l, 7'h7F);
        check("midrst_an_l", an_l, 3'b111);
        reset = 1'b0;
        go_to(2);
        check("restart_an_c2", an_h, 3'b000);
        step();
        check("restart_an_c3", an_h, 3'b001);
        observe_slot("post_rst", 0, 7'h3F);
        observe_slot("post_rst", 1, 7'h3F);
        observe_slot("post_rst", 2, 7'h3F);
        go_to(0);
        check("post_rst_q", q_h, 1'b1);
        observe_slot("post_rst_f2", 0, 7'h3F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
